// File: rtl/browse_pkg.sv
// Shared types and key indices for the browse control stage.
package browse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    BROWSE
  } state_t;

  localparam logic [1:0] K_INC  = 2'd0;
  localparam logic [1:0] K_DEC  = 2'd1;
  localparam logic [1:0] K_HOME = 2'd2;
  localparam logic [1:0] K_RUN  = 2'd3;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-FF synchronizer, level debounce and press pulse.
// level is active-high (pressed=1); press pulses on an accepted 0->1 change.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;
  logic          pressed_sync;

  assign pressed_sync = ~sync2_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      // Any cycle that agrees with the accepted level restarts the count.
      if (pressed_sync != level_reg) begin
        if (cnt_reg == CNT_LAST) begin
          level_reg <= pressed_sync;
          press_reg <= pressed_sync;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/browse_ctrl.sv
// Pushbutton-driven control: launches the range block with a latched start
// value, then browses the result RAM with auto-repeating step keys.
module browse_ctrl
  import browse_pkg::*;
#(
  parameter int RAM_WORDS       = 256,
  parameter int RAM_ADDR_BITS   = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 3145728
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               KEY,
  input  logic [9:0]               SW,
  input  logic                     done,
  output logic                     go,
  output logic [31:0]              start,
  output logic [RAM_ADDR_BITS-1:0] addr,
  output logic [11:0]              n,
  output logic                     ready
);

  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  localparam logic [RAM_ADDR_BITS-1:0] OFF_MAX = RAM_ADDR_BITS'(RAM_WORDS - 1);

  logic [3:0] key_level;
  logic [3:0] key_press;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key (
        .clk   (clk),
        .reset (reset),
        .key_n (KEY[gi]),
        .level (key_level[gi]),
        .press (key_press[gi])
      );
    end
  endgenerate

  state_t                   state_reg, state_next;
  logic [9:0]               base_reg, base_next;
  logic [RAM_ADDR_BITS-1:0] offset_reg, offset_next;
  logic                     go_reg, go_next;
  logic                     ready_reg, ready_next;
  logic [11:0]              n_reg, n_next;
  logic [RW-1:0]            rep_cnt_reg, rep_cnt_next;
  logic                     rep_fire;
  logic                     step_held;
  logic                     step_press;
  logic                     inc_step;
  logic                     dec_step;

  assign step_held  = key_level[K_INC] | key_level[K_DEC];
  assign step_press = key_press[K_INC] | key_press[K_DEC];

  // One shared repeat timer; a fresh press on either step key restarts it.
  always_comb begin
    rep_cnt_next = rep_cnt_reg;
    rep_fire     = 1'b0;
    if (!step_held || step_press) begin
      rep_cnt_next = '0;
    end else if (rep_cnt_reg == REP_LAST) begin
      rep_cnt_next = '0;
      rep_fire     = 1'b1;
    end else begin
      rep_cnt_next = rep_cnt_reg + 1'b1;
    end
  end

  // A held inc key masks dec entirely, so simultaneous holds only climb.
  assign inc_step = key_press[K_INC] | (key_level[K_INC] & rep_fire);
  assign dec_step = ~key_level[K_INC] & (key_press[K_DEC] | (key_level[K_DEC] & rep_fire));

  always_comb begin
    state_next  = state_reg;
    base_next   = base_reg;
    offset_next = offset_reg;
    go_next     = 1'b0;
    ready_next  = ready_reg;
    if (key_press[K_RUN]) begin
      base_next   = SW;
      offset_next = '0;
      ready_next  = 1'b0;
      go_next     = 1'b1;
      state_next  = RUN;
    end else begin
      case (state_reg)
        IDLE: begin
        end
        RUN: begin
          // done is not trusted while the go pulse itself is still out.
          if (done && !go_reg) begin
            state_next = BROWSE;
            ready_next = 1'b1;
          end
        end
        BROWSE: begin
          if (!key_level[K_RUN]) begin
            if (key_press[K_HOME]) begin
              offset_next = '0;
            end else if (!key_level[K_HOME]) begin
              if (inc_step) begin
                if (offset_reg != OFF_MAX) offset_next = offset_reg + 1'b1;
              end else if (dec_step) begin
                if (offset_reg != '0) offset_next = offset_reg - 1'b1;
              end
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign n_next = 12'(base_next) + 12'(offset_next);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      base_reg    <= '0;
      offset_reg  <= '0;
      go_reg      <= 1'b0;
      ready_reg   <= 1'b0;
      n_reg       <= '0;
      rep_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      base_reg    <= base_next;
      offset_reg  <= offset_next;
      go_reg      <= go_next;
      ready_reg   <= ready_next;
      n_reg       <= n_next;
      rep_cnt_reg <= rep_cnt_next;
    end
  end

  assign go    = go_reg;
  assign start = {22'd0, base_reg};
  assign addr  = offset_reg;
  assign n     = n_reg;
  assign ready = ready_reg;

endmodule

// File: tb/tb_browse_ctrl.sv
// Bench for browse_ctrl: directed plan plus random key/done traffic against
// a cycle-level behavioural model built from sample-history windows.
module tb_browse_ctrl;

  localparam int DEB   = 4;
  localparam int REP   = 8;
  localparam int WORDS = 16;
  localparam int AB    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    KEY;
  logic [9:0]    SW;
  logic          done;
  logic          go;
  logic [31:0]   start;
  logic [AB-1:0] addr;
  logic [11:0]   n;
  logic          ready;

  int checks;
  int errors;
  int go_seen;

  browse_ctrl #(
    .RAM_WORDS       (WORDS),
    .RAM_ADDR_BITS   (AB),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .KEY   (KEY),
    .SW    (SW),
    .done  (done),
    .go    (go),
    .start (start),
    .addr  (addr),
    .n     (n),
    .ready (ready)
  );

  always #5 clk = ~clk;

  // Model state: raw key history, accepted levels, press pulses, browse state.
  logic [DEB+1:0] m_hist [4];
  logic [3:0]     m_acc;
  logic [3:0]     m_press;
  int             m_state;  // 0 idle, 1 run, 2 browse
  int             m_base;
  int             m_off;
  int             m_hold;
  logic           m_go;
  logic           m_ready;

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_hist[k] = '1;
    m_acc = '0; m_press = '0;
    m_state = 0; m_base = 0; m_off = 0; m_hold = 0;
    m_go = 1'b0; m_ready = 1'b0;
  endtask

  task automatic model_clock();
    logic [3:0] lv;
    logic [3:0] pr;
    logic       was_go;
    logic       fire;
    lv = m_acc; pr = m_press; was_go = m_go; fire = 1'b0;
    m_go = 1'b0;
    // Repeat: a step every REP cycles counted from the latest press.
    if (!(lv[0] || lv[1]) || pr[0] || pr[1]) m_hold = 0;
    else begin
      m_hold++;
      fire = ((m_hold % REP) == 0);
    end
    if (pr[3]) begin
      m_base = int'(SW); m_off = 0; m_ready = 1'b0; m_go = 1'b1; m_state = 1;
    end else if (m_state == 1) begin
      if (done && !was_go) begin m_state = 2; m_ready = 1'b1; end
    end else if (m_state == 2 && !lv[3]) begin
      if (pr[2]) m_off = 0;
      else if (!lv[2]) begin
        if (pr[0] || (lv[0] && fire)) m_off = (m_off < WORDS - 1) ? m_off + 1 : m_off;
        else if (!lv[0] && (pr[1] || (lv[1] && fire))) m_off = (m_off > 0) ? m_off - 1 : 0;
      end
    end
    // Accept a new level once the last DEB synchronized samples all oppose it.
    for (int k = 0; k < 4; k++) begin
      m_press[k] = 1'b0;
      if (m_hist[k][DEB:1] == {DEB{m_acc[k]}}) begin
        m_acc[k]   = ~m_acc[k];
        m_press[k] = m_acc[k];
      end
      m_hist[k] = {m_hist[k][DEB:0], KEY[k]};
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_clock();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("go", 32'(go), 32'(m_go));
    chk("start", start, 32'(m_base));
    chk("addr", 32'(addr), 32'(m_off));
    chk("n", 32'(n), 32'((m_base + m_off) % 4096));
    chk("ready", 32'(ready), 32'(m_ready));
  end

  task automatic cyc(input int cnt);
    repeat (cnt) begin
      @(negedge clk);
      if (go) go_seen++;
    end
  endtask

  task automatic key_pulse(input logic [3:0] mask, input int low, input int high);
    KEY = ~mask;
    cyc(low);
    KEY = 4'hF;
    cyc(high);
  endtask

  task automatic done_pulse();
    done = 1'b1;
    cyc(1);
    done = 1'b0;
    cyc(2);
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_go", 32'(go), 0);
    chk("rst_start", start, 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_n", 32'(n), 0);
    chk("rst_ready", 32'(ready), 0);
    cyc(2);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; go_seen = 0;
    KEY = 4'hF; SW = '0; done = 1'b0; reset = 1'b0;
    #2 reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(2);
    chk("reset_n", 32'(n), 0);
    chk("reset_ready", 32'(ready), 0);

    // Run and browse entry.
    SW = 10'd27; go_seen = 0;
    key_pulse(4'b1000, 10, 10);
    chk("run_go_count", go_seen, 1);
    chk("run_start", start, 27);
    chk("run_n", 32'(n), 27);
    chk("run_ready", 32'(ready), 0);
    done_pulse();
    chk("browse_ready", 32'(ready), 1);
    chk("browse_addr", 32'(addr), 0);

    // Debounce.
    key_pulse(4'b0001, 3, 10);
    chk("glitch_addr", 32'(addr), 0);
    key_pulse(4'b0001, 6, 10);
    chk("step_n", 32'(n), 28);
    chk("step_addr", 32'(addr), 1);

    // Auto-repeat with saturation.
    key_pulse(4'b0001, 200, 12);
    chk("top_addr", 32'(addr), 15);
    chk("top_n", 32'(n), 42);
    chk("model_top", m_off, 15);
    key_pulse(4'b0010, 200, 12);
    chk("bottom_addr", 32'(addr), 0);
    chk("bottom_n", 32'(n), 27);

    // Priority.
    key_pulse(4'b0011, 6, 10);
    chk("both_addr", 32'(addr), 1);
    for (int i = 0; i < 8; i++) key_pulse(4'b0001, 6, 10);
    chk("nine_addr", 32'(addr), 9);
    key_pulse(4'b0100, 6, 10);
    chk("home_addr", 32'(addr), 0);
    chk("home_n", 32'(n), 27);

    // Restart during RUN.
    go_seen = 0;
    key_pulse(4'b1000, 8, 10);
    SW = 10'd5;
    key_pulse(4'b1000, 8, 10);
    chk("restart_go_count", go_seen, 2);
    chk("restart_start", start, 5);
    chk("restart_ready", 32'(ready), 0);
    done_pulse();
    chk("restart_ready2", 32'(ready), 1);
    chk("restart_n", 32'(n), 5);
    chk("model_base", m_base, 5);

    // Async reset mid-repeat, then KEY0 must do nothing until a run.
    KEY = 4'b1110;
    cyc(30);
    chk("prereset_addr", 32'(addr), 3);
    async_reset();
    cyc(40);
    chk("idle_addr", 32'(addr), 0);
    chk("idle_ready", 32'(ready), 0);
    KEY = 4'hF;
    cyc(12);

    // Random traffic.
    for (int i = 0; i < 250; i++) begin
      logic [3:0] k;
      int         dur;
      k[0] = 1'($urandom_range(0, 1));
      k[1] = 1'($urandom_range(0, 1));
      k[2] = ($urandom_range(0, 5) != 0);
      k[3] = ($urandom_range(0, 7) != 0);
      KEY = k;
      SW  = 10'($urandom_range(0, 1023));
      dur = $urandom_range(1, 40);
      repeat (dur) begin
        cyc(1);
        done = ($urandom_range(0, 9) == 0);
      end
      done = 1'b0;
      if ($urandom_range(0, 39) == 0) async_reset();
    end
    KEY = 4'hF;
    cyc(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/browse_ctrl.md
Name: browse_ctrl

Overview:
- Control stage directly upstream of the range/hex display path.
- Turns raw active-low pushbuttons into debounced, auto-repeating commands.
- Issues a one-cycle go to the range block with a latched start value, then steps a browse offset through the result RAM once done arrives.
- Drives the RAM read address and the 12-bit value n shown on HEX5..HEX3.

Parameters:
- RAM_WORDS, 256, number of result entries; offset saturates at RAM_WORDS-1.
- RAM_ADDR_BITS, 8, offset/address width.
- DEBOUNCE_CYCLES, 1000000, cycles a synchronized key level must hold before it is accepted (20 ms at 50 MHz).
- REPEAT_CYCLES, 3145728, cycles between auto-repeat steps while a step key is held.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-high reset.
- KEY  in  4  raw pushbuttons, active-low; KEY[0]=inc, KEY[1]=dec, KEY[2]=home, KEY[3]=run.
- SW  in  10  start value source.
- done  in  1  range block finished; one-cycle or level, sampled only in RUN.
- go  out  1  one-cycle start pulse to range.
- start  out  32  {22'd0, latched SW}, stable from go until the next run.
- addr  out  RAM_ADDR_BITS  result RAM read address (= offset).
- n  out  12  base + offset, value to display.
- ready  out  1  high in BROWSE (results valid).

Behaviour:
- Reset (async, any cycle, including mid-RUN or mid-repeat):
  - go=0, start=0, addr=0, n=0, ready=0.
  - All debounce/repeat counters 0; debounced keys = released; state IDLE.
- Key input conditioning:
  - Each KEY bit passes a 2-FF synchronizer, then an inverter (pressed=1).
  - Debounce: the accepted level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any glitch resets the count.
  - Press event = one-cycle pulse on a 0->1 edge of the accepted level.
- FSM states: IDLE, RUN, BROWSE.
  - Run event from any state: latch base=SW, start={22'd0,SW}, offset=0, ready=0. go=1 on the next cycle for exactly one cycle, then enter RUN.
  - KEY3 held does not repeat.
  - RUN: wait for done (ignored in the go cycle itself). On done, enter BROWSE, ready=1 the following cycle. KEY0..2 are ignored.
  - A run event during RUN restarts: new base, new go pulse.
  - BROWSE: step commands act on offset. IDLE ignores KEY0..2.
- Step commands:
  - Priority: KEY3 > KEY2 > KEY0 > KEY1. When KEY0 and KEY1 are both accepted-pressed, only KEY0 acts.
  - KEY0 press event: offset+1, saturating at RAM_WORDS-1 (no wrap).
  - KEY1 press event: offset-1, saturating at 0.
  - KEY2 press event: offset=0.
- Auto-repeat:
  - Applies while KEY0 or KEY1 stays accepted-pressed.
  - A repeat counter starts at 0 on the press event; each time it reaches REPEAT_CYCLES-1 it performs one further step and reloads to 0.
  - Release clears the counter.
  - Saturation holds offset without a wrap or glitch.
- Outputs:
  - addr = offset, registered.
  - n = base[11:0] + {4'd0, offset}, registered, 12-bit mod 4096 (max 1023+255 = 1278, so no wrap in practice).
  - n and addr update in the same cycle.

Decomposition:
- Package browse_pkg holds:
  - state_t enum {IDLE, RUN, BROWSE};
  - key index constants K_INC=0, K_DEC=1, K_HOME=2, K_RUN=3.
- One sub-module, key_debounce (synchronizer + debounce + press-pulse for one key, parameterized by DEBOUNCE_CYCLES), instantiated 4 times.
- Repeat counter and FSM live in browse_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, RAM_WORDS=16, RAM_ADDR_BITS=4):
- Run and browse entry:
  - SW=10'd27, KEY3 low 10 cycles -> one go pulse, start=27, n=27, ready=0.
  - Then done for 1 cycle -> ready=1, addr=0.
- Debounce:
  - KEY0 low 3 cycles then high -> no step.
  - KEY0 low 6 cycles -> exactly one step, n=28, addr=1.
- Auto-repeat with saturation:
  - Hold KEY0 for 200 cycles from addr=1 -> addr climbs one step per 8 cycles and stops at 15; n=42.
  - Hold KEY1 -> back down to addr=0, n=27, no wrap to 15.
- Priority:
  - KEY0 and KEY1 pressed together -> increments only.
  - KEY2 press at addr=9 -> addr=0, n=27.
- Restart during RUN:
  - KEY3, then SW=5 and KEY3 again before done -> second go pulse, start=5.
  - done -> BROWSE with n=5.
- Async reset:
  - Assert reset mid-repeat in BROWSE -> all outputs 0 within the same cycle, state IDLE.
  - KEY0 ignored until the next run.
